reg_file_scoreboard: RTL and testbench

Parametrised register file with an integrated busy-bit scoreboard for the pipelined RISC-V core. It holds 2^ADDR_WIDTH registers of DATA_WIDTH bits, with two combinational read ports and one synchronous write port. Optional write-to-read bypass and hardwired-zero register 0 are selectable by parameter. Per-register busy bits, set at issue and cleared at writeback, plus a live busy count, let the decode stage detect RAW hazards without external tracking logic.

---
 rtl/reg_file_scoreboard_if.sv | 29 ++
 rtl/reg_file_scoreboard.sv | 98 +++++++++
 tb/tb_reg_file_scoreboard.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Register file bus: writeback, issue reservation and the two read ports.
// The master side (decode/writeback) drives selects and data; the slave side returns reads and busy status.
interface reg_file_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wEn;
    logic [ADDR_WIDTH-1:0] write_sel;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  issue_en;
    logic [ADDR_WIDTH-1:0] issue_sel;
    logic [ADDR_WIDTH-1:0] read_sel1;
    logic [ADDR_WIDTH-1:0] read_sel2;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;
    logic                  busy1;
    logic                  busy2;
    logic [ADDR_WIDTH:0]   busy_count;

    modport master (
        output wEn, write_sel, write_data, issue_en, issue_sel, read_sel1, read_sel2,
        input  read_data1, read_data2, busy1, busy2, busy_count
    );

    modport slave (
        input  wEn, write_sel, write_data, issue_en, issue_sel, read_sel1, read_sel2,
        output read_data1, read_data2, busy1, busy2, busy_count
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, one write port and per-register busy bits
// plus a running busy count used by decode for RAW hazard detection.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    reg_file_scoreboard_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]      busy_reg;
    logic [DEPTH-1:0]      busy_next;
    logic [DEPTH-1:0]      wr_hit;
    logic [DEPTH-1:0]      iss_hit;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  write_ok;
    logic                  issue_ok;
    logic                  count_inc;
    logic                  count_dec;

    // Accesses to register 0 are squashed here so nothing downstream needs to special-case it.
    assign write_ok = bus.wEn      && !((ZERO_REG != 0) && (bus.write_sel == '0));
    assign issue_ok = bus.issue_en && !((ZERO_REG != 0) && (bus.issue_sel == '0));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            assign wr_hit[gi]    = write_ok && (bus.write_sel == IDX);
            assign iss_hit[gi]   = issue_ok && (bus.issue_sel == IDX);
            // A new issue overrides a same-edge writeback: the newer producer is still outstanding.
            assign busy_next[gi] = iss_hit[gi] || (busy_reg[gi] && !wr_hit[gi]);
        end
    endgenerate

    assign count_inc  = issue_ok && !busy_reg[bus.issue_sel];
    assign count_dec  = write_ok && busy_reg[bus.write_sel] &&
                        !(issue_ok && (bus.issue_sel == bus.write_sel));
    assign count_next = count_reg + (ADDR_WIDTH+1)'(count_inc) - (ADDR_WIDTH+1)'(count_dec);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (write_ok) begin
                regs_reg[bus.write_sel] <= bus.write_data;
            end
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign bus.busy_count = count_reg;

    logic [ADDR_WIDTH-1:0] rsel  [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rbusy [2];

    assign rsel[0] = bus.read_sel1;
    assign rsel[1] = bus.read_sel2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            logic byp_hit;
            // Forwarding is suppressed while reset is low so outputs show the cleared state.
            assign byp_hit = (BYPASS != 0) && reset && write_ok && (bus.write_sel == rsel[gi]);

            always_comb begin
                rdata[gi] = regs_reg[rsel[gi]];
                rbusy[gi] = busy_reg[rsel[gi]];
                if (byp_hit) begin
                    rdata[gi] = bus.write_data;
                    if (!(issue_ok && (bus.issue_sel == rsel[gi]))) begin
                        rbusy[gi] = 1'b0;
                    end
                end
                if ((ZERO_REG != 0) && (rsel[gi] == '0)) begin
                    rdata[gi] = '0;
                    rbusy[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign bus.read_data1 = rdata[0];
    assign bus.read_data2 = rdata[1];
    assign bus.busy1      = rbusy[0];
    assign bus.busy2      = rbusy[1];
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Drives a default-parameter instance and a 16-bit/8-entry no-bypass instance with the same stimulus;
// expected outputs come from an array-based model and are checked by a queue-driven monitor.
module tb_reg_file_scoreboard;
    logic clk;
    logic rst_n;

    reg_file_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if0 ();
    reg_file_scoreboard_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if1 ();

    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clock(clk), .reset(rst_n), .bus(if0)
    );
    reg_file_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clock(clk), .reset(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int txn_id   = 0;

    // Reference model state, indexed by instance.
    logic [31:0] m_regs [2][32];
    bit          m_busy [2][32];

    // Current raw inputs, masked per instance when applied.
    bit          c_wen;
    logic [4:0]  c_wsel;
    logic [31:0] c_wdata;
    bit          c_ien;
    logic [4:0]  c_isel;
    logic [4:0]  c_rs1;
    logic [4:0]  c_rs2;

    function automatic int amask(int v);
        return (v == 0) ? 31 : 7;
    endfunction

    function automatic logic [31:0] dmask(int v);
        return (v == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] exp_rd(int v, int sel);
        int s = sel & amask(v);
        if (s == 0) return 32'd0;
        if (v == 0 && c_wen && (int'(c_wsel) & amask(v)) == s) return c_wdata & dmask(v);
        return m_regs[v][s];
    endfunction

    function automatic logic [31:0] exp_bz(int v, int sel);
        int s = sel & amask(v);
        if (s == 0) return 32'd0;
        if (v == 0 && c_wen && (int'(c_wsel) & amask(v)) == s &&
            !(c_ien && (int'(c_isel) & amask(v)) == s)) return 32'd0;
        return m_busy[v][s] ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_cnt(int v);
        int n = 0;
        for (int i = 0; i <= amask(v); i++) n += m_busy[v][i] ? 1 : 0;
        return 32'(n);
    endfunction

    task automatic model_clear();
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[v][i] = '0;
                m_busy[v][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int v = 0; v < 2; v++) begin
            int ws = int'(c_wsel) & amask(v);
            int is = int'(c_isel) & amask(v);
            if (c_wen && ws != 0) begin
                m_regs[v][ws] = c_wdata & dmask(v);
                m_busy[v][ws] = 1'b0;
            end
            if (c_ien && is != 0) m_busy[v][is] = 1'b1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int v = 0; v < 2; v++) begin
            e.id  = txn_id;
            e.rd1 = exp_rd(v, int'(c_rs1));
            e.rd2 = exp_rd(v, int'(c_rs2));
            e.b1  = exp_bz(v, int'(c_rs1));
            e.b2  = exp_bz(v, int'(c_rs2));
            e.cnt = exp_cnt(v);
            if (v == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        txn_id++;
    endtask

    // One cycle: inputs change just after a rising edge, so reset changes land between edges.
    task automatic cycle(input bit rst_lvl, input bit wen, input logic [4:0] wsel,
                         input logic [31:0] wdata, input bit ien, input logic [4:0] isel,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        c_wen = wen;  c_wsel = wsel; c_wdata = wdata;
        c_ien = ien;  c_isel = isel; c_rs1 = rs1; c_rs2 = rs2;
        if0.wEn = wen; if0.write_sel = wsel; if0.write_data = wdata;
        if0.issue_en = ien; if0.issue_sel = isel; if0.read_sel1 = rs1; if0.read_sel2 = rs2;
        if1.wEn = wen; if1.write_sel = wsel[2:0]; if1.write_data = wdata[15:0];
        if1.issue_en = ien; if1.issue_sel = isel[2:0]; if1.read_sel1 = rs1[2:0]; if1.read_sel2 = rs2[2:0];
        rst_n = rst_lvl;
        if (!rst_lvl) model_clear();
        push_expected();
        @(posedge clk);
        if (rst_lvl) model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int v, input int id,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d txn %0d: got %h required %h", name, v, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so each expected entry is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q0.size() > 0) begin
            e = q0.pop_front();
            chk("read_data1", 0, e.id, if0.read_data1, e.rd1);
            chk("read_data2", 0, e.id, if0.read_data2, e.rd2);
            chk("busy1", 0, e.id, 32'(if0.busy1), e.b1);
            chk("busy2", 0, e.id, 32'(if0.busy2), e.b2);
            chk("busy_count", 0, e.id, 32'(if0.busy_count), e.cnt);
            $display("txn %0d dut0 rd1=%h rd2=%h b1=%0d b2=%0d cnt=%0d", e.id,
                     if0.read_data1, if0.read_data2, if0.busy1, if0.busy2, if0.busy_count);
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            chk("read_data1", 1, e.id, 32'(if1.read_data1), e.rd1);
            chk("read_data2", 1, e.id, 32'(if1.read_data2), e.rd2);
            chk("busy1", 1, e.id, 32'(if1.busy1), e.b1);
            chk("busy2", 1, e.id, 32'(if1.busy2), e.b2);
            chk("busy_count", 1, e.id, 32'(if1.busy_count), e.cnt);
            $display("txn %0d dut1 rd1=%h rd2=%h b1=%0d b2=%0d cnt=%0d", e.id,
                     if1.read_data1, if1.read_data2, if1.busy1, if1.busy2, if1.busy_count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        c_wen = 0; c_wsel = '0; c_wdata = '0; c_ien = 0; c_isel = '0; c_rs1 = '0; c_rs2 = '0;
        if0.wEn = 0; if0.write_sel = '0; if0.write_data = '0; if0.issue_en = 0;
        if0.issue_sel = '0; if0.read_sel1 = '0; if0.read_sel2 = '0;
        if1.wEn = 0; if1.write_sel = '0; if1.write_data = '0; if1.issue_en = 0;
        if1.issue_sel = '0; if1.read_sel1 = '0; if1.read_sel2 = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Reset held for two cycles, then dump every register.
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 0, 0, 5'(2*i), 5'(2*i+1));

        // Basic writes, with a same-cycle read of r1.
        cycle(1, 1, 5'd1,  32'h0000_0001, 0, 0, 5'd1, 5'd0);
        cycle(1, 1, 5'd31, 32'h0000_003F, 0, 0, 5'd1, 5'd31);
        cycle(1, 0, 0, 0, 0, 0, 5'd1, 5'd31);

        // Register 0 ignores writes and issues.
        cycle(1, 1, 5'd0, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd0);
        cycle(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0);

        // Scoreboard set/clear.
        cycle(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd7);
        cycle(1, 0, 0, 0, 1, 5'd7, 5'd5, 5'd7);
        cycle(1, 0, 0, 0, 0, 0, 5'd5, 5'd7);
        cycle(1, 1, 5'd5, 32'h1234_5678, 0, 0, 5'd5, 5'd7);
        cycle(1, 0, 0, 0, 0, 0, 5'd5, 5'd7);

        // Simultaneous issue and write to r7.
        cycle(1, 1, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 5'd7, 5'd5);
        cycle(1, 0, 0, 0, 0, 0, 5'd7, 5'd7);

        // Same-cycle read during write: bypassed on dut0, old value on dut1.
        cycle(1, 1, 5'd2, 32'h0000_BEEF, 0, 0, 5'd2, 5'd2);
        cycle(1, 0, 0, 0, 0, 0, 5'd2, 5'd2);

        // Asynchronous reset asserted between edges with r3 written and busy.
        cycle(1, 1, 5'd3, 32'h0000_0055, 0, 0, 5'd3, 5'd3);
        cycle(1, 0, 0, 0, 1, 5'd3, 5'd3, 5'd3);
        cycle(1, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        cycle(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd3);
        cycle(0, 0, 0, 0, 1, 5'd4, 5'd3, 5'd4);
        cycle(1, 0, 0, 0, 0, 0, 5'd3, 5'd4);

        // Randomised traffic, biased toward few registers so hazards collide often.
        for (int n = 0; n < 400; n++) begin
            bit          rl  = ($urandom_range(0, 99) != 0);
            bit          wen = rl && ($urandom_range(0, 1) == 1);
            bit          ien = ($urandom_range(0, 2) == 0);
            logic [4:0]  ws  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            logic [4:0]  is  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            logic [4:0]  r1  = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
            logic [4:0]  r2  = ($urandom_range(0, 3) == 0) ? is : 5'($urandom_range(0, 7));
            cycle(rl, wen, ws, $urandom, ien, is, r1, r2);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", q0.size() + q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
